// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output stage holding the fetched instruction and its address.
module fetch_out_reg
    import fetch_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic               ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;

    // Flush wins over load; an accepted entry empties unless refilled.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign valid     = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, fetch FSM and retired-fetch counter in front of decode.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [7:0]  START_PC  = 8'h00,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, flush, accept, slot_free;

    assign accept    = instr_valid && instr_ready;
    assign slot_free = !instr_valid || instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        flush   = 1'b0;

        if (accept && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = word_align(START_PC);
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (branch_taken) begin
                    pc_d  = word_align(branch_target);
                    flush = 1'b1;
                end else if (slot_free) begin
                    load = 1'b1;
                    // The halt word is presented but pc stays on it.
                    if (mem_instr == HALT_WORD)
                        state_d = ST_DRAIN;
                    else
                        pc_d = pc_q + PC_STEP;
                end
            end
            ST_DRAIN: begin
                if (branch_taken) begin
                    pc_d    = word_align(branch_target);
                    flush   = 1'b1;
                    state_d = ST_FETCH;
                end else if (accept) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    fetch_out_reg u_out (
        .clk       (clk),
        .rst       (reset),
        .load      (load),
        .flush     (flush),
        .ready     (instr_ready),
        .instr_in  (mem_instr),
        .pc_in     (pc_q),
        .instr_out (instr_out),
        .pc_out    (pc_out),
        .valid     (instr_valid)
    );

    assign mem_addr    = pc_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vectors, hand sequences and randomized checking against a behavioural model.
module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, branch_taken, instr_ready;
    logic [7:0]  branch_target, mem_addr, pc_out;
    logic [31:0] mem_instr, instr_out;
    logic        instr_valid, halted;
    logic [15:0] fetch_count;

    logic        w_start, w_ready;
    logic [7:0]  w_mem_addr, w_pc_out;
    logic [31:0] w_mem_instr, w_instr_out;
    logic        w_valid, w_halted;
    logic [2:0]  w_count;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_instr   = mem[mem_addr[7:2]];
    assign w_mem_instr = mem[w_mem_addr[7:2]];

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr),
        .mem_instr(mem_instr), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted), .fetch_count(fetch_count)
    );

    fetch_sequencer #(.START_PC(8'hFA), .CNT_W(3)) dut_w (
        .clk(clk), .reset(reset), .start(w_start), .mem_addr(w_mem_addr),
        .mem_instr(w_mem_instr), .branch_taken(1'b0), .branch_target(8'h00),
        .instr_out(w_instr_out), .pc_out(w_pc_out), .instr_valid(w_valid),
        .instr_ready(w_ready), .halted(w_halted), .fetch_count(w_count)
    );

    function automatic logic [31:0] word_at(input logic [7:0] a);
        return 32'h1000_0000 | {24'h0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic b, input logic [7:0] t);
        start = s; instr_ready = r; branch_taken = b; branch_target = t;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1; #2;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       start, ready, br;
        logic [7:0] tgt;
        logic       exp_valid;
        logic [7:0] exp_pcout, exp_addr;
        logic [15:0] exp_cnt;
    } vec_t;

    // Behavioural model: what the sequencer should present after each edge
    logic        m_valid, m_running, m_draining, m_stopped;
    logic [7:0]  m_pc, m_pcout;
    logic [31:0] m_instr;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_valid = 0; m_running = 0; m_draining = 0; m_stopped = 0;
        m_pc = 0; m_pcout = 0; m_instr = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic b, input logic [7:0] t);
        logic taken;
        taken = m_valid && r;
        if (taken && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (!m_running && !m_draining) begin
            if (s) begin
                m_pc = 8'h00; m_cnt = 0; m_running = 1; m_stopped = 0;
            end
        end else if (b) begin
            m_pc = t & 8'hFC; m_valid = 0; m_running = 1; m_draining = 0;
        end else if (m_draining) begin
            if (taken) begin
                m_valid = 0; m_draining = 0; m_stopped = 1;
            end
        end else if (!m_valid || taken) begin
            m_instr = mem[m_pc[7:2]];
            m_pcout = m_pc;
            m_valid = 1;
            if (m_instr == HALT) begin
                m_running = 0; m_draining = 1;
            end else begin
                m_pc = m_pc + 8'd4;
            end
        end
    endtask

    vec_t vt [14];

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 16'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h04, 16'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h08, 16'd1};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 8'h08, 16'd1};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 8'h08, 16'd1};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 8'h08, 16'd1};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 8'h0C, 16'd2};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0C, 8'h10, 16'd3};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 8'h23, 1'b0, 8'h00, 8'h20, 16'd4};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h20, 8'h24, 16'd4};
        vt[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h24, 8'h28, 16'd5};
        vt[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h28, 8'h2C, 16'd6};
        vt[12] = '{1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'h40, 16'd6};
        vt[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 8'h44, 16'd6};

        for (int i = 0; i < 64; i++) mem[i] = word_at(8'(i * 4));
        reset = 1'b1; start = 0; branch_taken = 0; branch_target = 0; instr_ready = 0;
        w_start = 0; w_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_pc", 64'(mem_addr), 64'd0);
        chk("rst_instr", 64'(instr_out), 64'd0);
        chk("rst_pcout", 64'(pc_out), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);
        reset = 1'b0;

        // Directed table: stream, backpressure, branch, start ignored in FETCH
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].start, vt[i].ready, vt[i].br, vt[i].tgt);
            chk($sformatf("vec%0d_valid", i), 64'(instr_valid), 64'(vt[i].exp_valid));
            chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vt[i].exp_addr));
            chk($sformatf("vec%0d_count", i), 64'(fetch_count), 64'(vt[i].exp_cnt));
            if (vt[i].exp_valid) begin
                chk($sformatf("vec%0d_pcout", i), 64'(pc_out), 64'(vt[i].exp_pcout));
                chk($sformatf("vec%0d_instr", i), 64'(instr_out), 64'(word_at(vt[i].exp_pcout)));
            end
        end
        start = 0; branch_taken = 0;

        // Asynchronous reset in the middle of a cycle with valid data held
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(instr_valid), 64'd0);
        chk("arst_pc", 64'(mem_addr), 64'd0);
        chk("arst_count", 64'(fetch_count), 64'd0);
        chk("arst_halted", 64'(halted), 64'd0);
        #1 reset = 1'b0;

        // Wrap across 8'hFC with misaligned START_PC, then counter saturation
        @(posedge clk); #1;
        w_start = 1; w_ready = 1;
        @(posedge clk); #1;
        w_start = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ea;
            ea = 8'hF8 + 8'(i * 4);
            @(posedge clk); #1;
            chk($sformatf("wrap%0d_valid", i), 64'(w_valid), 64'd1);
            chk($sformatf("wrap%0d_pcout", i), 64'(w_pc_out), 64'(ea));
            chk($sformatf("wrap%0d_instr", i), 64'(w_instr_out), 64'(word_at(ea)));
        end
        chk("wrap_count", 64'(w_count), 64'd3);
        chk("wrap_halted", 64'(w_halted), 64'd0);
        repeat (6) @(posedge clk);
        #1 chk("sat_count", 64'(w_count), 64'd7);
        @(posedge clk); #1 chk("sat_hold", 64'(w_count), 64'd7);
        w_ready = 0;

        // Halt word at 8'h0C with backpressure while draining
        mem[3] = HALT;
        do_reset();
        drive(1, 1, 0, 8'h00);
        drive(0, 1, 0, 8'h00);
        drive(0, 1, 0, 8'h00);
        drive(0, 1, 0, 8'h00);
        drive(0, 1, 0, 8'h00);
        chk("halt_cap_instr", 64'(instr_out), 64'(HALT));
        chk("halt_cap_pcout", 64'(pc_out), 64'h0C);
        chk("halt_cap_addr", 64'(mem_addr), 64'h0C);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 8'h00);
            chk($sformatf("drain%0d_valid", i), 64'(instr_valid), 64'd1);
            chk($sformatf("drain%0d_instr", i), 64'(instr_out), 64'(HALT));
            chk($sformatf("drain%0d_halted", i), 64'(halted), 64'd0);
        end
        drive(0, 1, 0, 8'h00);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_valid", 64'(instr_valid), 64'd0);
        chk("halt_count", 64'(fetch_count), 64'd4);
        drive(0, 1, 1, 8'h80);
        chk("halt_br_ign_halted", 64'(halted), 64'd1);
        chk("halt_br_ign_addr", 64'(mem_addr), 64'h0C);
        drive(1, 1, 0, 8'h00);
        chk("restart_halted", 64'(halted), 64'd0);
        chk("restart_addr", 64'(mem_addr), 64'h00);
        chk("restart_count", 64'(fetch_count), 64'd0);
        drive(0, 1, 0, 8'h00);
        chk("restart_valid", 64'(instr_valid), 64'd1);
        chk("restart_instr", 64'(instr_out), 64'(word_at(8'h00)));

        // Randomized run against the model
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
        start = 0; branch_taken = 0;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic s, r, b;
            logic [7:0] t;
            s = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 9) == 0);
            t = 8'($urandom);
            model_step(s, r, b, t);
            drive(s, r, b, t);
            chk("rnd_valid", 64'(instr_valid), 64'(m_valid));
            chk("rnd_addr", 64'(mem_addr), 64'(m_pc));
            chk("rnd_halted", 64'(halted), 64'(m_stopped));
            chk("rnd_count", 64'(fetch_count), 64'(m_cnt));
            if (m_valid) begin
                chk("rnd_instr", 64'(instr_out), 64'(m_instr));
                chk("rnd_pcout", 64'(pc_out), 64'(m_pcout));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences the byte-addressed 256-byte instruction memory: holds the program counter and drives the memory address. Registers each 32-bit instruction into a one-entry output stage with a valid/ready handshake toward decode. Handles branch redirects, stops on a halt word, and counts retired fetches. Sits between the instruction memory and the decode/control unit of the datapath.

Parameters:
START_PC, 8'h00, byte address loaded on start; low 2 bits forced to 0
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that ends fetching
CNT_W, 16, width of the fetch counter

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins fetching from START_PC (honoured in IDLE and HALT only)
mem_addr  output  8  byte address to the instruction memory; always equals pc
mem_instr  input  32  combinational read data returned for mem_addr
branch_taken  input  1  redirect request from the control unit
branch_target  input  8  redirect byte address; low 2 bits ignored and treated as 0
instr_out  output  32  registered instruction presented to decode
pc_out  output  8  byte address that instr_out was fetched from
instr_valid  output  1  instr_out/pc_out are valid
instr_ready  input  1  decode accepts instr_out this cycle
halted  output  1  high while in HALT
fetch_count  output  CNT_W  number of accepted instructions (valid & ready), saturating

Behaviour:
- Reset (asynchronous, any time): state=IDLE, pc=0, instr_out=0, pc_out=0, instr_valid=0, halted=0, fetch_count=0. Reset asserted mid-fetch discards the output stage.
- States: IDLE, FETCH, DRAIN, HALT.
- IDLE: mem_addr=pc; no capture. start -> pc=START_PC&~3, fetch_count=0, state=FETCH.
- Slot free: instr_valid=0 or (instr_valid & instr_ready).
- FETCH, slot free, no branch: instr_out<=mem_instr, pc_out<=pc, instr_valid<=1, pc<=pc+4 (8-bit wrap: 8'hFC -> 8'h00). If mem_instr==HALT_WORD, pc does not advance and state=DRAIN.
- FETCH, slot not free: hold all registers (stall); instr_out stable while valid and not ready.
- Throughput: one instruction per cycle with instr_ready held high; first instr_valid one cycle after start.
- Branch (FETCH or DRAIN): pc<=branch_target&~3, instr_valid<=0 (output flushed), state=FETCH; the new target is captured the following cycle (branch-to-valid latency = 2 cycles). Branch has priority over capture and over the DRAIN->HALT transition. If instr_ready was also high that cycle, the presented instruction counts as accepted.
- Branch in IDLE or HALT: ignored.
- DRAIN: holds the halt word valid; on instr_valid & instr_ready -> instr_valid<=0, state=HALT.
- HALT: halted=1, no fetch, pc holds address of the halt word; start -> as in IDLE (halted<=0).
- start in FETCH/DRAIN: ignored.
- fetch_count: +1 on every cycle with instr_valid & instr_ready, saturates at all-ones; cleared by reset or accepted start.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, HALT=2'd3), PC_W=8, INSTR_W=32, PC_STEP=4.
- One natural sub-module: fetch_out_reg (one-entry valid/ready register holding instr_out/pc_out with load/flush/hold). The FSM, pc and counter stay in fetch_sequencer.

Test Plan:
- Reset then start, instr_ready=1, memory words at 0,4,8 = A,B,C -> instr_out A/B/C with pc_out 0/4/8 on consecutive cycles; first valid 1 cycle after start; fetch_count=3 after 3 accepts.
- Backpressure: instr_ready=0 for 3 cycles while B is presented -> instr_out=B, pc_out=4, mem_addr=8 held stable; on ready, C follows next cycle; no instruction lost or duplicated.
- Branch: branch_taken with target 8'h23 while pc=8'h10 -> instr_valid=0 next cycle, mem_addr=8'h20, instruction from 8'h20 valid the cycle after.
- Wrap: start with START_PC=8'hF8, no halt word in memory -> pc_out sequence F8, FC, 00, 04.
- Halt: HALT_WORD at 8'h0C, instr_ready=0 for 2 cycles at the halt word -> DRAIN holds it valid; after accept halted=1, instr_valid=0, branch then ignored, start restarts at START_PC with fetch_count=0.
- Asynchronous reset asserted mid-cycle during FETCH with valid data -> instr_valid, halted, pc, fetch_count go to 0 immediately, before the next clock edge.
